draw_scheduler: RTL and testbench

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/draw_sched_pkg.sv | 39 +++
 rtl/draw_scheduler_if.sv | 32 +++
 rtl/draw_scheduler_rr_arbiter.sv | 32 +++
 rtl/draw_scheduler.sv | 135 +++++++++++++
 tb/tb_draw_scheduler.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | draw_sched_pkg : shared constants, state encoding, helper functions  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package draw_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int POS_W   = 3;

  localparam logic [POS_W-1:0] MAX_PRESS_POS = 3'd5;
  localparam logic [POS_W-1:0] MAX_GARB_POS  = 3'd3;

  localparam logic [IDX_W-1:0] REQ_PRESS_ERASE = 2'd0;
  localparam logic [IDX_W-1:0] REQ_PRESS_DRAW  = 2'd1;
  localparam logic [IDX_W-1:0] REQ_GARB_DRAW   = 2'd2;
  localparam logic [IDX_W-1:0] REQ_GARB_ERASE  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // item=1 selects the press (positions 0..5), item=0 the garbage (0..3)
  function automatic logic pos_valid(input logic item, input logic [POS_W-1:0] pos);
    return item ? (pos <= MAX_PRESS_POS) : (pos <= MAX_GARB_POS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/draw_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | draw_scheduler_if : requester and drawer-command bundle              |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface draw_scheduler_if;

  logic [3:0]  req;
  logic [3:0]  req_item;
  logic [3:0]  req_erase;
  logic [11:0] req_pos;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic        cmd_valid;
  logic        item;
  logic        erase;
  logic [2:0]  position;
  logic        busy;

  modport master (
    output req, req_item, req_erase, req_pos,
    input  gnt, done, err, cmd_valid, item, erase, position, busy
  );

  modport slave (
    input  req, req_item, req_erase, req_pos,
    output gnt, done, err, cmd_valid, item, erase, position, busy
  );

endinterface
`default_nettype wire

// File: rtl/draw_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick after last_grant         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter
  import draw_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  always_comb begin
    logic [IDX_W-1:0] v_idx;
    logic             v_found;
    pick    = '0;
    v_idx   = '0;
    v_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = last_grant + IDX_W'(k + 1);
      if (!v_found && req[v_idx]) begin
        pick[v_idx] = 1'b1;
        v_found     = 1'b1;
      end
    end
    any = v_found;
  end

endmodule
`default_nettype wire

// File: rtl/draw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | draw_scheduler : round-robin job scheduler driving one drawer        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module draw_scheduler #(
  parameter int DRAW_CYCLES = 2402,
  parameter int NUM_REQ     = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  draw_scheduler_if.slave  bus
);

  import draw_sched_pkg::*;

  localparam int               c_cnt_w    = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(DRAW_CYCLES - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [IDX_W-1:0]   r_last_grant;
  logic [NUM_REQ-1:0] r_sel;
  logic               r_item;
  logic               r_erase;
  logic [POS_W-1:0]   r_pos;
  logic               r_err;

  logic [NUM_REQ-1:0] w_pick;
  logic               w_any;
  logic [IDX_W-1:0]   w_idx;
  logic               w_item;
  logic               w_erase;
  logic [POS_W-1:0]   w_pos;
  logic               w_valid;

  rr_arbiter u_arb (
    .req        (bus.req),
    .last_grant (r_last_grant),
    .pick       (w_pick),
    .any        (w_any)
  );

  // Mux the picked requester's job fields
  always_comb begin
    w_item  = 1'b0;
    w_erase = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_item  = bus.req_item[i];
        w_erase = bus.req_erase[i];
        w_pos   = bus.req_pos[i*POS_W +: POS_W];
      end
    end
  end

  assign w_idx   = onehot_to_idx(w_pick);
  assign w_valid = pos_valid(w_item, w_pos);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next_state = w_valid ? ST_HOLD : ST_DONE;
      ST_HOLD: if (r_cnt == c_last_cnt) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Job fields are captured only at selection, so requester changes during HOLD are ignored
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_last_grant <= REQ_GARB_ERASE;
      r_sel        <= '0;
      r_item       <= 1'b0;
      r_erase      <= 1'b0;
      r_pos        <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_sel        <= w_pick;
            r_item       <= w_item;
            r_erase      <= w_erase;
            r_pos        <= w_pos;
            r_err        <= ~w_valid;
            r_last_grant <= w_idx;
          end
        end
        ST_HOLD: begin
          if (r_cnt == c_last_cnt) r_cnt <= '0;
          else                     r_cnt <= r_cnt + c_cnt_w'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    bus.gnt       = '0;
    bus.done      = '0;
    bus.err       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.item      = 1'b0;
    bus.erase     = 1'b0;
    bus.position  = '0;
    bus.busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_HOLD: begin
        bus.gnt       = r_sel;
        bus.cmd_valid = 1'b1;
        bus.item      = r_item;
        bus.erase     = r_erase;
        bus.position  = r_pos;
      end
      ST_DONE: begin
        bus.done = r_sel;
        bus.err  = r_err;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_draw_scheduler : directed self-checking bench, DRAW_CYCLES = 8    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_draw_scheduler;

  localparam int DC = 8;

  logic CLOCK_50 = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  draw_scheduler_if bus ();

  draw_scheduler #(.DRAW_CYCLES(DC), .NUM_REQ(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req       = '0;
    bus.req_item  = '0;
    bus.req_erase = '0;
    bus.req_pos   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++;
    if ({bus.gnt, bus.done, bus.err, bus.cmd_valid, bus.item, bus.erase, bus.position, bus.busy} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs gnt=%b done=%b err=%b cv=%b item=%b erase=%b pos=%0d busy=%b expected all 0",
               bus.gnt, bus.done, bus.err, bus.cmd_valid, bus.item, bus.erase, bus.position, bus.busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin
      failures++;
      $display("FAIL reset_release_idle busy=%b gnt=%b expected busy=0 gnt=0000", bus.busy, bus.gnt);
    end
  endtask

  task automatic test_basic();
    bus.req_item[0]  = 1'b1;
    bus.req_erase[0] = 1'b1;
    bus.req_pos[2:0] = 3'd5;
    bus.req          = 4'b0001;
    checks++;
    if (bus.gnt !== 4'b0) begin
      failures++;
      $display("FAIL basic_c0_gnt gnt=%b expected 0000", bus.gnt);
    end
    for (int c = 1; c <= DC; c++) begin
      tick();
      if (c == 1) bus.req = 4'b0;
      checks++;
      if (bus.gnt !== 4'b0001 || bus.cmd_valid !== 1'b1 || bus.position !== 3'd5 ||
          bus.item !== 1'b1 || bus.erase !== 1'b1 || bus.done !== 4'b0) begin
        failures++;
        $display("FAIL basic_hold c=%0d gnt=%b cv=%b pos=%0d item=%b erase=%b done=%b expected 0001 1 5 1 1 0000",
                 c, bus.gnt, bus.cmd_valid, bus.position, bus.item, bus.erase, bus.done);
      end
    end
    tick();
    checks++;
    if (bus.done !== 4'b0001 || bus.err !== 1'b0 || bus.gnt !== 4'b0 || bus.cmd_valid !== 1'b0 ||
        bus.position !== 3'd0 || bus.item !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_done done=%b err=%b gnt=%b cv=%b pos=%0d item=%b busy=%b expected 0001 0 0000 0 0 0 1",
               bus.done, bus.err, bus.gnt, bus.cmd_valid, bus.position, bus.item, bus.busy);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 4'b0) begin
      failures++;
      $display("FAIL basic_idle busy=%b done=%b expected 0 0000", bus.busy, bus.done);
    end
  endtask

  task automatic test_round_robin();
    int ord[5] = '{0, 1, 2, 3, 0};
    int cyc;
    int target;
    logic [3:0] exp_gnt;
    do_reset();
    bus.req_item = 4'hF;
    bus.req      = 4'hF;
    cyc = 0;
    for (int j = 0; j < 5; j++) begin
      target = 1 + j * (DC + 2);
      while (cyc < target) begin
        tick();
        cyc++;
        if (j > 0 && cyc == target - 1) begin
          checks++;
          if (bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin
            failures++;
            $display("FAIL rr_gap j=%0d cyc=%0d busy=%b gnt=%b expected 0 0000", j, cyc, bus.busy, bus.gnt);
          end
        end
      end
      exp_gnt = 4'b0001 << ord[j];
      checks++;
      if (bus.gnt !== exp_gnt) begin
        failures++;
        $display("FAIL rr_order j=%0d cyc=%0d gnt=%b expected %b", j, cyc, bus.gnt, exp_gnt);
      end
    end
    bus.req = 4'b0;
    repeat (DC + 2) tick();
  endtask

  task automatic test_invalid();
    logic [4:0] tbl[4] = '{{1'b0, 3'd3, 1'b1}, {1'b0, 3'd4, 1'b0}, {1'b1, 3'd6, 1'b0}, {1'b1, 3'd7, 1'b0}};
    logic [4:0] e;
    bus.req_item[2]  = 1'b0;
    bus.req_pos[8:6] = 3'd6;
    bus.req          = 4'b0100;
    tick();
    bus.req = 4'b0;
    checks++;
    if (bus.done !== 4'b0100 || bus.err !== 1'b1 || bus.gnt !== 4'b0 || bus.cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL invalid_reject done=%b err=%b gnt=%b cv=%b expected 0100 1 0000 0",
               bus.done, bus.err, bus.gnt, bus.cmd_valid);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 4'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL invalid_idle busy=%b done=%b err=%b expected 0 0000 0", bus.busy, bus.done, bus.err);
    end
    for (int t = 0; t < 4; t++) begin
      e = tbl[t];
      bus.req_item[1]  = e[4];
      bus.req_pos[5:3] = e[3:1];
      bus.req          = 4'b0010;
      tick();
      bus.req = 4'b0;
      checks++;
      if (e[0] ? (bus.gnt !== 4'b0010 || bus.err !== 1'b0 || bus.done !== 4'b0)
               : (bus.gnt !== 4'b0 || bus.err !== 1'b1 || bus.done !== 4'b0010)) begin
        failures++;
        $display("FAIL pos_bound item=%b pos=%0d gnt=%b err=%b done=%b expected valid=%b",
                 e[4], e[3:1], bus.gnt, bus.err, bus.done, e[0]);
      end
      repeat (DC + 1) tick();
    end
  endtask

  task automatic test_hold_ignore();
    bus.req_item[1]  = 1'b1;
    bus.req_erase[1] = 1'b0;
    bus.req_pos[5:3] = 3'd2;
    bus.req          = 4'b0010;
    for (int c = 1; c <= DC; c++) begin
      tick();
      if (c == 3) begin
        bus.req_pos[5:3] = 3'd4;
        bus.req_item[1]  = 1'b0;
        bus.req_erase[1] = 1'b1;
        bus.req          = 4'b0;
      end
      checks++;
      if (bus.gnt !== 4'b0010 || bus.position !== 3'd2 || bus.item !== 1'b1 || bus.erase !== 1'b0) begin
        failures++;
        $display("FAIL hold_latched c=%0d gnt=%b pos=%0d item=%b erase=%b expected 0010 2 1 0",
                 c, bus.gnt, bus.position, bus.item, bus.erase);
      end
    end
    tick();
    checks++;
    if (bus.done !== 4'b0010) begin
      failures++;
      $display("FAIL hold_done done=%b expected 0010", bus.done);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_idle busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic saw_done;
    bus.req_item[0]  = 1'b1;
    bus.req_pos[2:0] = 3'd1;
    bus.req          = 4'b0001;
    repeat (4) tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_pre gnt=%b expected 0001", bus.gnt);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0 || bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async gnt=%b cv=%b busy=%b expected 0000 0 0", bus.gnt, bus.cmd_valid, bus.busy);
    end
    bus.req = 4'b0;
    tick();
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (DC + 4) begin
      tick();
      saw_done = saw_done | (|bus.done);
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_done saw_done=%b expected 0", saw_done);
    end
    bus.req_item[3]   = 1'b1;
    bus.req_pos[11:9] = 3'd0;
    bus.req           = 4'b1000;
    tick();
    bus.req = 4'b0;
    checks++;
    if (bus.gnt !== 4'b1000 || bus.cmd_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_regrant gnt=%b cv=%b expected 1000 1", bus.gnt, bus.cmd_valid);
    end
    repeat (DC + 1) tick();
    // After reset requester 0 must beat requester 3
    do_reset();
    bus.req_item = 4'hF;
    bus.req      = 4'b1001;
    tick();
    bus.req = 4'b0;
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_start0 gnt=%b expected 0001", bus.gnt);
    end
    repeat (DC + 1) tick();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_round_robin();
    test_invalid();
    test_hold_ignore();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
